// File: rtl/imsic_msi_recv.sv
// IMSIC MSI receive stage: decodes setipnum_le writes per hart/interrupt file,
// queues valid MSIs and presents each as a stable info word with a level-held valid.
module imsic_msi_recv #(
  parameter int NR_INTP_FILES   = 7,
  parameter int NR_HARTS        = 4,
  parameter int NR_HARTS_WIDTH  = 2,
  parameter int NR_SRC          = 32,
  parameter int ADDR_WIDTH      = 17,
  parameter int FIFO_DEPTH      = 4,
  parameter int VLD_HIGH        = 4,
  parameter int VLD_LOW         = 4,
  parameter int NR_SRC_WIDTH    = $clog2(NR_SRC),
  parameter int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  parameter int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_wr_vld,
  output logic                      o_wr_rdy,
  input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
  input  logic [31:0]               i_wr_data,
  output logic                      o_resp_vld,
  output logic                      o_resp_err,
  input  logic                      i_resp_rdy,
  output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
  output logic                      o_msi_info_vld,
  output logic [15:0]               o_drop_cnt
);

  localparam int PAGE_W = ADDR_WIDTH - 12;
  localparam int FAW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2((VLD_HIGH > VLD_LOW) ? VLD_HIGH : VLD_LOW) + 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        vld_d;
  logic                        load, pop;
  logic                        rdy_en_q;

  logic [PAGE_W-1:0]           page;
  logic [NR_HARTS_WIDTH-1:0]   hart;
  logic [INTP_FILE_WIDTH-1:0]  file;
  logic                        wr_ok;
  logic                        accept, push;

  logic [MSI_INFO_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FAW:0]                wptr_q, rptr_q;
  logic                        full, empty;

  // Address decode: one 4 KiB page per interrupt file, files grouped per hart.
  assign page  = i_wr_addr[ADDR_WIDTH-1:12];
  assign hart  = NR_HARTS_WIDTH'(page / PAGE_W'(NR_INTP_FILES));
  assign file  = INTP_FILE_WIDTH'(page % PAGE_W'(NR_INTP_FILES));
  assign wr_ok = (32'(page) < 32'(NR_HARTS * NR_INTP_FILES))
               && (i_wr_addr[11:0] == '0)
               && (i_wr_data[31:NR_SRC_WIDTH] == '0)
               && (i_wr_data != '0);

  assign full  = (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]) && (wptr_q[FAW] != rptr_q[FAW]);
  assign empty = (wptr_q == rptr_q);

  // rdy_en_q keeps ready low while in reset and for no longer than the first edge after it.
  assign o_wr_rdy = rdy_en_q & ~full & ~(o_resp_vld & ~i_resp_rdy);
  assign accept   = i_wr_vld & o_wr_rdy;
  assign push     = accept & wr_ok;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[FAW-1:0]] <= {hart, file, i_wr_data[NR_SRC_WIDTH-1:0]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en_q   <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      o_resp_vld <= 1'b0;
      o_resp_err <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wptr_q <= wptr_q + (FAW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (FAW+1)'(1);
      if (accept) begin
        o_resp_vld <= 1'b1;
        o_resp_err <= ~wr_ok;
      end else if (i_resp_rdy) begin
        o_resp_vld <= 1'b0;
        o_resp_err <= 1'b0;
      end
      if (accept && !wr_ok && (o_drop_cnt != '1)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = o_msi_info_vld;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          vld_d   = 1'b1;
          cnt_d   = CNT_W'(VLD_HIGH - 1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          vld_d   = 1'b0;
          cnt_d   = CNT_W'(VLD_LOW - 1);
          state_d = LOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        // Head entry is retired only after the low phase so the info word stays stable.
        if (cnt_q == '0) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      o_msi_info_vld <= 1'b0;
      o_msi_info     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      o_msi_info_vld <= vld_d;
      if (load) o_msi_info <= mem[rptr_q[FAW-1:0]];
    end
  end

endmodule

// File: tb/tb_imsic_msi_recv.sv
// Directed bench for imsic_msi_recv: decode vector table plus back-pressure,
// response-stall and mid-emission reset sequences.
module tb_imsic_msi_recv;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_wr_vld;
  logic        o_wr_rdy;
  logic [16:0] i_wr_addr;
  logic [31:0] i_wr_data;
  logic        o_resp_vld;
  logic        o_resp_err;
  logic        i_resp_rdy;
  logic [9:0]  o_msi_info;
  logic        o_msi_info_vld;
  logic [15:0] o_drop_cnt;

  imsic_msi_recv #(
    .NR_INTP_FILES(7),
    .NR_HARTS(4),
    .NR_HARTS_WIDTH(2),
    .NR_SRC(32),
    .ADDR_WIDTH(17),
    .FIFO_DEPTH(4),
    .VLD_HIGH(4),
    .VLD_LOW(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_wr_vld(i_wr_vld),
    .o_wr_rdy(o_wr_rdy),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .o_resp_vld(o_resp_vld),
    .o_resp_err(o_resp_err),
    .i_resp_rdy(i_resp_rdy),
    .o_msi_info(o_msi_info),
    .o_msi_info_vld(o_msi_info_vld),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Rising edges of the MSI valid, recorded on the falling clock edge.
  int         rise_cyc[$];
  logic [9:0] rise_info[$];
  logic       vld_prev = 1'b0;
  always @(negedge clk) begin
    if (o_msi_info_vld && !vld_prev) begin
      rise_cyc.push_back(cyc);
      rise_info.push_back(o_msi_info);
    end
    vld_prev = o_msi_info_vld;
  end

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
    logic        err;
    logic [9:0]  info;
    logic [15:0] drop;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic send(input logic [16:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    i_wr_vld  = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      ok = o_wr_rdy;
      tick();
    end
    i_wr_vld = 1'b0;
    chk("send_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_emit(input string name, input logic [9:0] exp_info);
    int n;
    tick();
    chk({name, "_vld_latency"}, {31'd0, o_msi_info_vld}, 32'd1);
    chk({name, "_info"}, {22'd0, o_msi_info}, {22'd0, exp_info});
    chk({name, "_resp_clear"}, {31'd0, o_resp_vld}, 32'd0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_msi_info_vld) n++;
      else break;
    end
    chk({name, "_high_cycles"}, n, 4);
    repeat (8) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc[6];
    int   k;
    bit   ok, bad;

    vecs[0] = '{17'h01000, 32'd5,          1'b0, 10'h025, 16'd0};
    vecs[1] = '{17'h1B000, 32'd31,         1'b0, 10'h3DF, 16'd0};
    vecs[2] = '{17'h1C000, 32'd5,          1'b1, 10'h000, 16'd1};
    vecs[3] = '{17'h01000, 32'd0,          1'b1, 10'h000, 16'd2};
    vecs[4] = '{17'h01000, 32'd32,         1'b1, 10'h000, 16'd3};
    vecs[5] = '{17'h01000, 32'h8000_0005,  1'b1, 10'h000, 16'd4};
    vecs[6] = '{17'h01004, 32'd5,          1'b1, 10'h000, 16'd5};
    vecs[7] = '{17'h00000, 32'd1,          1'b0, 10'h001, 16'd5};
    vecs[8] = '{17'h07000, 32'd17,         1'b0, 10'h111, 16'd5};

    rstn = 1'b0; i_wr_vld = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_resp_rdy = 1'b1;
    #2;
    chk("rst_wr_rdy", {31'd0, o_wr_rdy}, 32'd0);
    chk("rst_resp_vld", {31'd0, o_resp_vld}, 32'd0);
    chk("rst_resp_err", {31'd0, o_resp_err}, 32'd0);
    chk("rst_info", {22'd0, o_msi_info}, 32'd0);
    chk("rst_info_vld", {31'd0, o_msi_info_vld}, 32'd0);
    chk("rst_drop_cnt", {16'd0, o_drop_cnt}, 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_wr_rdy", {31'd0, o_wr_rdy}, 32'd1);
    repeat (2) tick();

    for (int v = 0; v < 9; v++) begin
      send(vecs[v].addr, vecs[v].data);
      chk($sformatf("vec%0d_resp_vld", v), {31'd0, o_resp_vld}, 32'd1);
      chk($sformatf("vec%0d_resp_err", v), {31'd0, o_resp_err}, {31'd0, vecs[v].err});
      if (!vecs[v].err) begin
        check_emit($sformatf("vec%0d", v), vecs[v].info);
      end else begin
        bad = 1'b0;
        repeat (8) begin
          tick();
          if (o_msi_info_vld) bad = 1'b1;
        end
        chk($sformatf("vec%0d_no_vld", v), {31'd0, bad}, 32'd0);
      end
      chk($sformatf("vec%0d_drop_cnt", v), {16'd0, o_drop_cnt}, {16'd0, vecs[v].drop});
    end

    // Back-pressure: six back-to-back writes into a four-deep queue.
    rise_cyc.delete(); rise_info.delete();
    i_wr_addr = 17'h01000;
    k = 0;
    i_wr_vld = 1'b1;
    i_wr_data = 32'd1;
    for (int i = 0; i < 200 && k < 6; i++) begin
      #1;
      ok = o_wr_rdy;
      tick();
      if (ok) begin
        acc[k] = cyc;
        k++;
        i_wr_data = 32'(k + 1);
      end
    end
    i_wr_vld = 1'b0;
    chk("bp_all_accepted", k, 6);
    if (k == 6) begin
      chk("bp_gap1", acc[1] - acc[0], 1);
      chk("bp_gap2", acc[2] - acc[1], 1);
      chk("bp_gap3", acc[3] - acc[2], 1);
      chk("bp_gap4_first_pop", acc[4] - acc[3], 7);
      chk("bp_gap5", acc[5] - acc[4], 9);
    end
    for (int i = 0; i < 100 && rise_cyc.size() < 6; i++) tick();
    repeat (12) tick();
    chk("bp_emit_count", rise_cyc.size(), 6);
    if (rise_cyc.size() == 6 && k == 6) begin
      chk("bp_first_latency", rise_cyc[0] - acc[0], 1);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("bp_info%0d", i), {22'd0, rise_info[i]}, 32'h20 | 32'(i + 1));
        if (i > 0) chk($sformatf("bp_period%0d", i), rise_cyc[i] - rise_cyc[i-1], 9);
      end
    end

    // Response stall blocks acceptance until the response is taken.
    rise_cyc.delete(); rise_info.delete();
    send(17'h01000, 32'd7);
    i_resp_rdy = 1'b0;
    #1;
    chk("stall_resp_vld", {31'd0, o_resp_vld}, 32'd1);
    chk("stall_wr_rdy", {31'd0, o_wr_rdy}, 32'd0);
    i_wr_vld = 1'b1; i_wr_addr = 17'h01000; i_wr_data = 32'd9;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (!o_resp_vld || o_resp_err || o_wr_rdy) bad = 1'b1;
    end
    chk("stall_held", {31'd0, bad}, 32'd0);
    i_resp_rdy = 1'b1;
    #1;
    chk("stall_release_rdy", {31'd0, o_wr_rdy}, 32'd1);
    tick();
    i_wr_vld = 1'b0;
    chk("stall_second_resp", {31'd0, o_resp_vld}, 32'd1);
    tick();
    chk("stall_resp_done", {31'd0, o_resp_vld}, 32'd0);
    for (int i = 0; i < 40 && rise_cyc.size() < 2; i++) tick();
    repeat (12) tick();
    chk("stall_emit_count", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2) begin
      chk("stall_info0", {22'd0, rise_info[0]}, 32'h027);
      chk("stall_info1", {22'd0, rise_info[1]}, 32'h029);
    end
    chk("stall_drop_cnt", {16'd0, o_drop_cnt}, 32'd5);

    // Reset while the first of three MSIs is high and two remain queued.
    rise_cyc.delete(); rise_info.delete();
    send(17'h01000, 32'd10);
    send(17'h01000, 32'd11);
    send(17'h01000, 32'd12);
    chk("mid_vld_high", {31'd0, o_msi_info_vld}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", {31'd0, o_msi_info_vld}, 32'd0);
    chk("mid_rst_info", {22'd0, o_msi_info}, 32'd0);
    chk("mid_rst_resp", {31'd0, o_resp_vld}, 32'd0);
    chk("mid_rst_rdy", {31'd0, o_wr_rdy}, 32'd0);
    chk("mid_rst_drop", {16'd0, o_drop_cnt}, 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("mid_post_rdy", {31'd0, o_wr_rdy}, 32'd1);
    rise_cyc.delete(); rise_info.delete();
    repeat (12) tick();
    chk("mid_queue_flushed", rise_cyc.size(), 0);
    send(17'h02000, 32'd3);
    chk("mid_fresh_resp_err", {31'd0, o_resp_err}, 32'd0);
    check_emit("mid_fresh", 10'h043);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
